plca_rx_decode: RTL and testbench

- PLCA receive-side decoder between the PHY MII receive interface and the MAC.
- Decodes in-band BEACON and COMMIT requests from RX_DV/RX_ER/RXD into rx_cmd and derives receiving for the PLCA control and data state diagrams.
- Hides the command symbols from the MAC so that it sees only true frames and true carrier.
- It is the receive counterpart of the PLCA data block that encodes tx_cmd onto TXD/TX_ER.

---
 rtl/plca_rx_decode_if.sv | 33 +++
 rtl/plca_rx_decode.sv | 161 ++++++++++++++++
 tb/tb_plca_rx_decode.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/plca_rx_decode_if.sv
// PHY-side MII receive inputs and MAC-side outputs of the PLCA receive decoder.
// slave = decoder, master = whatever drives the PHY side and observes the MAC side.
interface plca_rx_decode_if #(
   parameter int CNT_W = 8
);
   logic             plca_en;
   logic             plca_status;
   logic [3:0]       RXD;
   logic             RX_DV;
   logic             RX_ER;
   logic             CRS;
   logic [1:0]       rx_cmd;
   logic             receiving;
   logic             beacon_det;
   logic [3:0]       RXD_MAC;
   logic             RX_DV_MAC;
   logic             RX_ER_MAC;
   logic             CRS_MAC;
   logic [1:0]       rx_dec_state;
   logic [CNT_W-1:0] beacon_cnt;
   logic [CNT_W-1:0] glitch_cnt;

   modport slave (
      input  plca_en, plca_status, RXD, RX_DV, RX_ER, CRS,
      output rx_cmd, receiving, beacon_det, RXD_MAC, RX_DV_MAC, RX_ER_MAC, CRS_MAC,
             rx_dec_state, beacon_cnt, glitch_cnt
   );
   modport master (
      output plca_en, plca_status, RXD, RX_DV, RX_ER, CRS,
      input  rx_cmd, receiving, beacon_det, RXD_MAC, RX_DV_MAC, RX_ER_MAC, CRS_MAC,
             rx_dec_state, beacon_cnt, glitch_cnt
   );
endinterface

// File: rtl/plca_rx_decode.sv
// PLCA receive decoder: qualifies BEACON/COMMIT symbols from the MII receive path,
// reports them on rx_cmd and hides them from the MAC. Every output is registered.
module plca_rx_decode #(
   parameter int CMD_QUAL = 2,
   parameter int CNT_W    = 8
)(
   input  logic           RX_CLK,
   input  logic           rst_n,
   plca_rx_decode_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, QUAL = 2'b01, CMD = 2'b10, DATA = 2'b11} state_t;
   typedef struct packed {
      logic [3:0] rxd;
      logic       dv;
      logic       er;
      logic       crs;
   } mii_t;

   localparam logic [1:0]       CMD_BEACON = 2'b00;
   localparam logic [1:0]       CMD_COMMIT = 2'b01;
   localparam logic [1:0]       CMD_NONE   = 2'b10;
   localparam logic [2:0]       QUAL_MAX   = 3'(CMD_QUAL);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t           state, state_nx;
   logic [2:0]       qcnt, qcnt_nx;
   logic [1:0]       cmd_lat, cmd_lat_nx;
   logic             entry, glitch, eval_idle;
   logic             bypass, is_cmd;
   logic [1:0]       enc;
   mii_t             phy, mac_q, mac_nx;
   logic [1:0]       rx_cmd_q, rx_cmd_nx;
   logic             receiving_q, receiving_nx;
   logic             beacon_det_q, beacon_det_nx;
   logic [CNT_W-1:0] beacon_cnt_q, glitch_cnt_q;

   assign phy    = {bus.RXD, bus.RX_DV, bus.RX_ER, bus.CRS};
   assign bypass = !bus.plca_en || !bus.plca_status;
   assign is_cmd = !bus.RX_DV && bus.RX_ER && (bus.RXD == 4'h2 || bus.RXD == 4'h3);
   assign enc    = bus.RXD[0] ? CMD_COMMIT : CMD_BEACON;

   always_ff @(posedge RX_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         qcnt    <= '0;
         cmd_lat <= CMD_NONE;
      end else begin
         state   <= state_nx;
         qcnt    <= qcnt_nx;
         cmd_lat <= cmd_lat_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      qcnt_nx    = qcnt;
      cmd_lat_nx = cmd_lat;
      entry      = 1'b0;
      glitch     = 1'b0;
      eval_idle  = 1'b0;
      if (bypass) begin
         state_nx = IDLE;
         qcnt_nx  = '0;
      end else begin
         case (state)
            IDLE: eval_idle = 1'b1;
            QUAL: begin
               if (is_cmd && enc == cmd_lat) begin
                  qcnt_nx = qcnt + 3'd1;
                  if (qcnt_nx >= QUAL_MAX) begin
                     state_nx = CMD;
                     qcnt_nx  = '0;
                     entry    = 1'b1;
                  end
               end else begin
                  // abandoned qualification: this cycle is treated as a fresh IDLE cycle
                  glitch    = 1'b1;
                  eval_idle = 1'b1;
               end
            end
            CMD: begin
               if (is_cmd)         cmd_lat_nx = enc;
               else if (bus.RX_DV) state_nx   = DATA;
               else                state_nx   = IDLE;
            end
            DATA: if (!bus.RX_DV && !bus.CRS) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
         if (eval_idle) begin
            qcnt_nx = '0;
            if (is_cmd) begin
               cmd_lat_nx = enc;
               if (CMD_QUAL <= 1) begin
                  state_nx = CMD;
                  entry    = 1'b1;
               end else begin
                  state_nx = QUAL;
                  qcnt_nx  = 3'd1;
               end
            end else if (bus.RX_DV) begin
               state_nx = DATA;
            end else begin
               state_nx = IDLE;
            end
         end
      end
   end

   // Outputs are computed from the next state so they land on the same edge as it.
   always_comb begin
      rx_cmd_nx     = (state_nx == CMD) ? cmd_lat_nx : CMD_NONE;
      beacon_det_nx = entry && (cmd_lat_nx == CMD_BEACON);
      mac_nx        = phy;
      receiving_nx  = phy.crs;
      if (!bypass) begin
         case (state_nx)
            IDLE:    receiving_nx = phy.crs;
            DATA:    receiving_nx = 1'b1;
            default: begin
               mac_nx       = '0;
               receiving_nx = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge RX_CLK or negedge rst_n) begin
      if (!rst_n) begin
         rx_cmd_q     <= CMD_NONE;
         receiving_q  <= 1'b0;
         beacon_det_q <= 1'b0;
         mac_q        <= '0;
      end else begin
         rx_cmd_q     <= rx_cmd_nx;
         receiving_q  <= receiving_nx;
         beacon_det_q <= beacon_det_nx;
         mac_q        <= mac_nx;
      end
   end

   always_ff @(posedge RX_CLK or negedge rst_n) begin
      if (!rst_n) begin
         beacon_cnt_q <= '0;
         glitch_cnt_q <= '0;
      end else begin
         if (beacon_det_nx && beacon_cnt_q != CNT_MAX) beacon_cnt_q <= beacon_cnt_q + 1'b1;
         if (glitch && glitch_cnt_q != CNT_MAX)        glitch_cnt_q <= glitch_cnt_q + 1'b1;
      end
   end

   assign bus.rx_cmd       = rx_cmd_q;
   assign bus.receiving    = receiving_q;
   assign bus.beacon_det   = beacon_det_q;
   assign bus.RXD_MAC      = mac_q.rxd;
   assign bus.RX_DV_MAC    = mac_q.dv;
   assign bus.RX_ER_MAC    = mac_q.er;
   assign bus.CRS_MAC      = mac_q.crs;
   assign bus.rx_dec_state = state;
   assign bus.beacon_cnt   = beacon_cnt_q;
   assign bus.glitch_cnt   = glitch_cnt_q;
endmodule

// File: tb/tb_plca_rx_decode.sv
// Directed bench for plca_rx_decode: a vector table stepped one RX_CLK per row,
// followed by async reset mid-frame and beacon counter saturation.
module tb_plca_rx_decode;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   plca_rx_decode_if #(.CNT_W(8)) bus();

   plca_rx_decode #(.CMD_QUAL(2), .CNT_W(8)) dut (
      .RX_CLK(clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en, st;
      logic [3:0] rxd;
      logic       dv, er, crs;
      logic [1:0] cmd;
      logic       rcv, bd;
      logic [3:0] rxdm;
      logic       dvm, erm, crsm;
      logic [1:0] stt;
      logic [7:0] bc, gc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic en, logic st, logic [3:0] rxd, logic dv, logic er,
                              logic crs, logic [1:0] cmd, logic rcv, logic bd,
                              logic [3:0] rxdm, logic dvm, logic erm, logic crsm,
                              logic [1:0] stt, logic [7:0] bc, logic [7:0] gc);
      vec_t r;
      r.en = en; r.st = st; r.rxd = rxd; r.dv = dv; r.er = er; r.crs = crs;
      r.cmd = cmd; r.rcv = rcv; r.bd = bd; r.rxdm = rxdm; r.dvm = dvm; r.erm = erm;
      r.crsm = crsm; r.stt = stt; r.bc = bc; r.gc = gc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input logic en, input logic st, input logic [3:0] rxd,
                       input logic dv, input logic er, input logic crs);
      @(negedge clk);
      bus.plca_en = en; bus.plca_status = st; bus.RXD = rxd;
      bus.RX_DV = dv; bus.RX_ER = er; bus.CRS = crs;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".rx_cmd"},     32'(bus.rx_cmd), 32'h2);
      chk({tag, ".receiving"},  32'(bus.receiving), 0);
      chk({tag, ".beacon_det"}, 32'(bus.beacon_det), 0);
      chk({tag, ".mac"},        32'({bus.RXD_MAC, bus.RX_DV_MAC, bus.RX_ER_MAC, bus.CRS_MAC}), 0);
      chk({tag, ".state"},      32'(bus.rx_dec_state), 0);
      chk({tag, ".beacon_cnt"}, 32'(bus.beacon_cnt), 0);
      chk({tag, ".glitch_cnt"}, 32'(bus.glitch_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      // cmd: B=0 C=1 N=2 ; state: IDLE=0 QUAL=1 CMD=2 DATA=3
      // en st rxd dv er crs | cmd rcv bd rxdm dvm erm crsm stt bc gc
      tbl.push_back(v(1,1,4'h2,0,1,0, 2,0,0,4'h0,0,0,0, 1, 0,0)); // beacon x5
      tbl.push_back(v(1,1,4'h2,0,1,0, 0,0,1,4'h0,0,0,0, 2, 1,0));
      tbl.push_back(v(1,1,4'h2,0,1,0, 0,0,0,4'h0,0,0,0, 2, 1,0));
      tbl.push_back(v(1,1,4'h2,0,1,0, 0,0,0,4'h0,0,0,0, 2, 1,0));
      tbl.push_back(v(1,1,4'h2,0,1,0, 0,0,0,4'h0,0,0,0, 2, 1,0));
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,0));
      tbl.push_back(v(1,1,4'h3,0,1,0, 2,0,0,4'h0,0,0,0, 1, 1,0)); // commit x4
      tbl.push_back(v(1,1,4'h3,0,1,0, 1,0,0,4'h0,0,0,0, 2, 1,0));
      tbl.push_back(v(1,1,4'h3,0,1,0, 1,0,0,4'h0,0,0,0, 2, 1,0));
      tbl.push_back(v(1,1,4'h3,0,1,0, 1,0,0,4'h0,0,0,0, 2, 1,0));
      tbl.push_back(v(1,1,4'h5,1,0,1, 2,1,0,4'h5,1,0,1, 3, 1,0)); // frame
      tbl.push_back(v(1,1,4'h5,1,0,1, 2,1,0,4'h5,1,0,1, 3, 1,0));
      tbl.push_back(v(1,1,4'hD,1,0,1, 2,1,0,4'hD,1,0,1, 3, 1,0));
      tbl.push_back(v(1,1,4'hA,1,0,1, 2,1,0,4'hA,1,0,1, 3, 1,0));
      tbl.push_back(v(1,1,4'h0,0,0,1, 2,1,0,4'h0,0,0,1, 3, 1,0));
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,0));
      tbl.push_back(v(1,1,4'h2,0,1,0, 2,0,0,4'h0,0,0,0, 1, 1,0)); // single-cycle glitch
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,1));
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,1));
      tbl.push_back(v(1,1,4'hE,0,1,1, 2,1,0,4'hE,0,1,1, 0, 1,1)); // false carrier x3
      tbl.push_back(v(1,1,4'hE,0,1,1, 2,1,0,4'hE,0,1,1, 0, 1,1));
      tbl.push_back(v(1,1,4'hE,0,1,1, 2,1,0,4'hE,0,1,1, 0, 1,1));
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,1));
      tbl.push_back(v(1,1,4'h2,0,1,0, 2,0,0,4'h0,0,0,0, 1, 1,1)); // B then C requalifies
      tbl.push_back(v(1,1,4'h3,0,1,0, 2,0,0,4'h0,0,0,0, 1, 1,2));
      tbl.push_back(v(1,1,4'h3,0,1,0, 1,0,0,4'h0,0,0,0, 2, 1,2));
      tbl.push_back(v(1,1,4'h2,0,1,0, 0,0,0,4'h0,0,0,0, 2, 1,2)); // switch in CMD, no pulse
      tbl.push_back(v(1,1,4'h3,0,1,0, 1,0,0,4'h0,0,0,0, 2, 1,2));
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,2));
      tbl.push_back(v(0,1,4'h2,0,1,0, 2,0,0,4'h2,0,1,0, 0, 1,2)); // plca_en=0 bypass
      tbl.push_back(v(0,1,4'h2,0,1,1, 2,1,0,4'h2,0,1,1, 0, 1,2));
      tbl.push_back(v(0,1,4'h2,0,1,1, 2,1,0,4'h2,0,1,1, 0, 1,2));
      tbl.push_back(v(1,0,4'h2,0,1,0, 2,0,0,4'h2,0,1,0, 0, 1,2)); // status FAIL bypass
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,2));
      tbl.push_back(v(1,1,4'h2,0,1,0, 2,0,0,4'h0,0,0,0, 1, 1,2)); // qualify vs en drop
      tbl.push_back(v(0,1,4'h2,0,1,0, 2,0,0,4'h2,0,1,0, 0, 1,2));
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,2));
      tbl.push_back(v(1,1,4'h5,1,0,1, 2,1,0,4'h5,1,0,1, 3, 1,2)); // command inside DATA
      tbl.push_back(v(1,1,4'h2,0,1,1, 2,1,0,4'h2,0,1,1, 3, 1,2));
      tbl.push_back(v(1,1,4'h0,0,0,0, 2,0,0,4'h0,0,0,0, 0, 1,2));

      bus.plca_en = 1'b1; bus.plca_status = 1'b1; bus.RXD = 4'h0;
      bus.RX_DV = 1'b0; bus.RX_ER = 1'b0; bus.CRS = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         tick(tbl[i].en, tbl[i].st, tbl[i].rxd, tbl[i].dv, tbl[i].er, tbl[i].crs);
         chk($sformatf("row%0d.rx_cmd", i),     32'(bus.rx_cmd),       32'(tbl[i].cmd));
         chk($sformatf("row%0d.receiving", i),  32'(bus.receiving),    32'(tbl[i].rcv));
         chk($sformatf("row%0d.beacon_det", i), 32'(bus.beacon_det),   32'(tbl[i].bd));
         chk($sformatf("row%0d.RXD_MAC", i),    32'(bus.RXD_MAC),      32'(tbl[i].rxdm));
         chk($sformatf("row%0d.RX_DV_MAC", i),  32'(bus.RX_DV_MAC),    32'(tbl[i].dvm));
         chk($sformatf("row%0d.RX_ER_MAC", i),  32'(bus.RX_ER_MAC),    32'(tbl[i].erm));
         chk($sformatf("row%0d.CRS_MAC", i),    32'(bus.CRS_MAC),      32'(tbl[i].crsm));
         chk($sformatf("row%0d.state", i),      32'(bus.rx_dec_state), 32'(tbl[i].stt));
         chk($sformatf("row%0d.beacon_cnt", i), 32'(bus.beacon_cnt),   32'(tbl[i].bc));
         chk($sformatf("row%0d.glitch_cnt", i), 32'(bus.glitch_cnt),   32'(tbl[i].gc));
      end

      // asynchronous reset in the middle of a frame
      tick(1, 1, 4'h5, 1, 0, 1);
      tick(1, 1, 4'hA, 1, 0, 1);
      chk("middata.state", 32'(bus.rx_dec_state), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_reset");
      @(negedge clk);
      bus.RXD = 4'h0; bus.RX_DV = 1'b0; bus.CRS = 1'b0;
      rst_n = 1'b1;

      // 300 beacons: each is two qualifying cycles plus one idle cycle
      pulses = 0;
      for (int n = 0; n < 300; n++) begin
         tick(1, 1, 4'h2, 0, 1, 0);
         if (bus.beacon_det) pulses++;
         tick(1, 1, 4'h2, 0, 1, 0);
         if (bus.beacon_det) pulses++;
         tick(1, 1, 4'h0, 0, 0, 0);
         if (bus.beacon_det) pulses++;
         if (n == 253) chk("beacon_cnt_254", 32'(bus.beacon_cnt), 254);
      end
      chk("beacon_pulses", 32'(pulses), 300);
      chk("beacon_cnt_sat", 32'(bus.beacon_cnt), 255);
      chk("glitch_after_beacons", 32'(bus.glitch_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
